mem_bus_master: RTL

CPU-side initiator for the shared multiplexed memory request bus.
- Turns a simple valid/ready load/store request into the bus sequences the memory responder expects.
- Write is a two-phase sequence: a data phase, then an address/commit phase.
- Read drives the address and samples the responder's combinational read data.
- Sits between the CPU load/store unit and the on-chip memory.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_master_if.sv | 29 ++
 rtl/mem_bus_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the mem_bus_master initiator.
package mem_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned IDLE_BUS   = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_ADDR = 3'd2,
        RD_ADDR = 3'd3,
        VERIFY  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// CPU request/response and memory bus signals of mem_bus_master.
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_error;
    logic                  memWriteReq;
    logic [ADDR_WIDTH-1:0] memReqBus;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error, memWriteReq, memReqBus
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, memWriteReq, memReqBus
    );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator turning CPU load/store requests into multiplexed memory bus sequences.
// Optional post-write readback check: define MEM_BUS_MASTER_READBACK_EN.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned READ_WAIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_master_if.master bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_bus;
    logic [ADDR_WIDTH-1:0] w_bus_nxt;
    logic                  r_mem_wreq;
    logic                  w_wreq_nxt;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  w_resp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_accept;
`ifdef MEM_BUS_MASTER_READBACK_EN
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_resp_error;
    logic                  w_error_nxt;
`endif

    assign w_accept = bus.req_valid && r_req_ready;

    // Next-state and next-output decode; every bus output is registered from these.
    always_comb begin
        w_state_nxt      = r_state;
        w_wait_nxt       = r_wait;
        w_wreq_nxt       = 1'b0;
        w_bus_nxt        = ADDR_WIDTH'(IDLE_BUS);
        w_resp_valid_nxt = 1'b0;
        w_rdata_nxt      = r_resp_rdata;
`ifdef MEM_BUS_MASTER_READBACK_EN
        w_error_nxt      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.req_write) begin
                        w_state_nxt = WR_DATA;
                        w_wreq_nxt  = 1'b1;
                        w_bus_nxt   = ADDR_WIDTH'(bus.req_wdata);
                    end else begin
                        w_state_nxt = RD_ADDR;
                        w_wait_nxt  = WAIT_W'(READ_WAIT);
                        w_bus_nxt   = bus.req_addr;
                    end
                end
            end
            WR_DATA: begin
                w_state_nxt = WR_ADDR;
                w_bus_nxt   = r_addr;
            end
            WR_ADDR: begin
`ifdef MEM_BUS_MASTER_READBACK_EN
                w_state_nxt = VERIFY;
                w_wait_nxt  = WAIT_W'(READ_WAIT);
                w_bus_nxt   = r_addr;
`else
                w_state_nxt      = IDLE;
                w_resp_valid_nxt = 1'b1;
`endif
            end
            RD_ADDR: begin
                if (r_wait == '0) begin
                    w_state_nxt      = IDLE;
                    w_resp_valid_nxt = 1'b1;
                    w_rdata_nxt      = bus.mem_rdata;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                    w_bus_nxt  = r_addr;
                end
            end
`ifdef MEM_BUS_MASTER_READBACK_EN
            VERIFY: begin
                if (r_wait == '0) begin
                    w_state_nxt      = IDLE;
                    w_resp_valid_nxt = 1'b1;
                    w_error_nxt      = (bus.mem_rdata != r_wdata);
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                    w_bus_nxt  = r_addr;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wait       <= '0;
            r_addr       <= '0;
            r_mem_wreq   <= 1'b0;
            r_mem_bus    <= ADDR_WIDTH'(IDLE_BUS);
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
`ifdef MEM_BUS_MASTER_READBACK_EN
            r_wdata      <= '0;
            r_resp_error <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_wait       <= w_wait_nxt;
            r_mem_wreq   <= w_wreq_nxt;
            r_mem_bus    <= w_bus_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_rdata_nxt;
            if (w_accept) begin
                r_addr <= bus.req_addr;
            end
`ifdef MEM_BUS_MASTER_READBACK_EN
            r_resp_error <= w_error_nxt;
            if (w_accept) begin
                r_wdata <= bus.req_wdata;
            end
`endif
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.memWriteReq = r_mem_wreq;
    assign bus.memReqBus   = r_mem_bus;
`ifdef MEM_BUS_MASTER_READBACK_EN
    assign bus.resp_error  = r_resp_error;
`else
    assign bus.resp_error  = 1'b0;
`endif

endmodule
